systolic_result_drain: RTL and testbench

Downstream stage of the 3x3 systolic multiplier. Captures the nine 16-bit products c1..c9 when the array raises done, then streams them out one element per transfer, row-major, over a valid/ready interface. Decouples the array from a slower consumer such as a UART/FIFO writer, and flags results lost to backpressure.

---
 rtl/systolic_pkg.sv | 17 +
 rtl/rise_detect.sv | 24 ++
 rtl/systolic_result_drain.sv | 126 ++++++++++++
 tb/tb_systolic_result_drain.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the 3x3 systolic multiplier and its result drain:
// element width, burst length, index width and the drain state encoding.
package systolic_pkg;

  localparam int DATA_W = 16;
  localparam int N_ELEM = 9;
  localparam int IDX_W  = 4;

  // Index of the final element of a burst (C[2][2])
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered 1-bit rising-edge detector. The delayed copy of the input is
// cleared by reset, so an input that is already high when reset is released
// shows up as one rising edge on the first cycle out of reset.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // Keep a one-cycle delayed copy of the input so the edge can be compared against it
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/systolic_result_drain.sv
// Result drain for the 3x3 systolic multiplier. Nine products are captured
// on the rising edge of done_i and streamed out row-major, one element per
// valid/ready transfer. A done edge that arrives while a burst is still
// draining is dropped and remembered in the sticky overrun flag. The only
// exception is a done edge on the final transfer, which reloads the buffer
// and starts the next burst without a gap.
module systolic_result_drain
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              done_i,
  input  logic [DATA_W-1:0] c1_i,
  input  logic [DATA_W-1:0] c2_i,
  input  logic [DATA_W-1:0] c3_i,
  input  logic [DATA_W-1:0] c4_i,
  input  logic [DATA_W-1:0] c5_i,
  input  logic [DATA_W-1:0] c6_i,
  input  logic [DATA_W-1:0] c7_i,
  input  logic [DATA_W-1:0] c8_i,
  input  logic [DATA_W-1:0] c9_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              overrun_o
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] buf_q [N_ELEM];
  logic [DATA_W-1:0] in_vec [N_ELEM];
  logic              done_rise;
  logic              xfer;
  logic              at_last;
  logic              load;

  assign in_vec[0] = c1_i;
  assign in_vec[1] = c2_i;
  assign in_vec[2] = c3_i;
  assign in_vec[3] = c4_i;
  assign in_vec[4] = c5_i;
  assign in_vec[5] = c6_i;
  assign in_vec[6] = c7_i;
  assign in_vec[7] = c8_i;
  assign in_vec[8] = c9_i;

  rise_detect u_done_rise (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (done_i),
    .rise_o (done_rise)
  );

  assign xfer    = (state_q == SEND) & out_ready_i;
  assign at_last = (idx_q == LAST_IDX);

  // Next-state logic: decide whether to capture, advance the index, finish the burst or flag an overrun
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (done_rise) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (at_last) begin
            idx_d = '0;
            if (done_rise) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        if (done_rise && !(xfer && at_last)) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, index, sticky overrun flag and capture buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_ELEM; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      if (load) begin
        for (int i = 0; i < N_ELEM; i++) begin
          buf_q[i] <= in_vec[i];
        end
      end
    end
  end

  assign out_valid_o = (state_q == SEND);
  assign busy_o      = (state_q == SEND);
  assign out_data_o  = out_valid_o ? buf_q[idx_q] : '0;
  assign out_idx_o   = idx_q;
  assign out_last_o  = out_valid_o & at_last;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain: a directed vector table,
// hand-written corner sequences, and a randomized phase checked against a
// queue-based model of the element stream.
module tb_systolic_result_drain;
  import systolic_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              done_i;
  logic              out_ready_i;
  logic [DATA_W-1:0] c_in [N_ELEM];
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic [IDX_W-1:0]  out_idx_o;
  logic              out_last_o;
  logic              busy_o;
  logic              overrun_o;

  systolic_result_drain dut (
    .clk         (clk),
    .rst         (rst),
    .done_i      (done_i),
    .c1_i        (c_in[0]),
    .c2_i        (c_in[1]),
    .c3_i        (c_in[2]),
    .c4_i        (c_in[3]),
    .c5_i        (c_in[4]),
    .c6_i        (c_in[5]),
    .c7_i        (c_in[6]),
    .c8_i        (c_in[7]),
    .c9_i        (c_in[8]),
    .out_ready_i (out_ready_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_idx_o   (out_idx_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  // Reference model: the pending elements of the current burst, in delivery order
  typedef struct {
    logic [15:0] data;
    int          idx;
  } elem_t;

  elem_t       modelQ [$];
  bit          modelOverrun = 1'b0;
  bit          modelPrevDone = 1'b0;

  typedef struct {
    bit          done;
    bit          ready;
    bit          expValid;
    logic [15:0] expData;
    int          expIdx;
    bit          expLast;
    bit          expOverrun;
  } vec_t;

  vec_t        vecs [$];
  logic [15:0] seenData [$];
  logic [15:0] nominal [N_ELEM];
  int          nVectors = 0;
  int          nMiscompares = 0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic modelStep();
    bit rise;
    bit xfer;
    if (rst) begin
      modelQ.delete();
      modelOverrun  = 1'b0;
      modelPrevDone = 1'b0;
      return;
    end
    rise = done_i && !modelPrevDone;
    modelPrevDone = done_i;
    xfer = (modelQ.size() > 0) && out_ready_i;
    if (xfer) void'(modelQ.pop_front());
    if (rise) begin
      if (modelQ.size() == 0) begin
        for (int k = 0; k < N_ELEM; k++) modelQ.push_back('{data: c_in[k], idx: k});
      end else begin
        modelOverrun = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    bit expValid;
    expValid = (modelQ.size() > 0);
    compare("model_valid", out_valid_o, expValid);
    compare("model_busy", busy_o, expValid);
    compare("model_overrun", overrun_o, modelOverrun);
    compare("model_last", out_last_o, expValid && modelQ[0].idx == N_ELEM - 1);
    if (expValid) begin
      compare("model_data", out_data_o, modelQ[0].data);
      compare("model_idx", out_idx_o, modelQ[0].idx);
    end
  endtask

  task automatic tick();
    if (!rst && out_valid_o === 1'b1 && out_ready_i) seenData.push_back(out_data_o);
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input bit r, input bit d, input bit rdy);
    rst         = r;
    done_i      = d;
    out_ready_i = rdy;
    tick();
  endtask

  task automatic addVec(input bit d, input bit rdy, input bit v, input logic [15:0] dat,
                        input int idx, input bit last, input bit ovr);
    vecs.push_back('{done: d, ready: rdy, expValid: v, expData: dat, expIdx: idx,
                     expLast: last, expOverrun: ovr});
  endtask

  task automatic setNominal();
    for (int k = 0; k < N_ELEM; k++) c_in[k] = nominal[k];
  endtask

  task automatic checkSeen(input string name, input logic [15:0] exp [$]);
    compare({name, "_count"}, seenData.size(), exp.size());
    for (int k = 0; k < exp.size() && k < seenData.size(); k++) begin
      compare(name, seenData[k], exp[k]);
    end
  endtask

  initial begin
    logic [15:0] expList [$];

    nominal = '{16'd84, 16'd90, 16'd96, 16'd201, 16'd216, 16'd231, 16'd318, 16'd342, 16'd366};
    setNominal();

    // Reset
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    compare("reset_valid", out_valid_o, 1'b0);
    compare("reset_data", out_data_o, 16'd0);
    compare("reset_idx", out_idx_o, 4'd0);
    compare("reset_last", out_last_o, 1'b0);
    compare("reset_busy", busy_o, 1'b0);
    compare("reset_overrun", overrun_o, 1'b0);
    rst = 1'b0;

    // Directed table: nominal full-rate burst, then a burst with a 3-cycle stall at idx 4
    addVec(1, 1, 1, nominal[0], 0, 0, 0);
    for (int k = 1; k < N_ELEM; k++) addVec(0, 1, 1, nominal[k], k, k == N_ELEM - 1, 0);
    addVec(0, 1, 0, 16'd0, 0, 0, 0);
    addVec(0, 1, 0, 16'd0, 0, 0, 0);
    addVec(1, 1, 1, nominal[0], 0, 0, 0);
    for (int k = 1; k <= 4; k++) addVec(0, 1, 1, nominal[k], k, 0, 0);
    for (int s = 0; s < 3; s++) addVec(0, 0, 1, nominal[4], 4, 0, 0);
    for (int k = 5; k < N_ELEM; k++) addVec(0, 1, 1, nominal[k], k, k == N_ELEM - 1, 0);
    addVec(0, 1, 0, 16'd0, 0, 0, 0);

    seenData.delete();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b0, vecs[i].done, vecs[i].ready);
      compare("tbl_valid", out_valid_o, vecs[i].expValid);
      compare("tbl_busy", busy_o, vecs[i].expValid);
      compare("tbl_overrun", overrun_o, vecs[i].expOverrun);
      compare("tbl_last", out_last_o, vecs[i].expLast);
      if (vecs[i].expValid) begin
        compare("tbl_data", out_data_o, vecs[i].expData);
        compare("tbl_idx", out_idx_o, vecs[i].expIdx);
      end
    end
    expList.delete();
    for (int r = 0; r < 2; r++) for (int k = 0; k < N_ELEM; k++) expList.push_back(nominal[k]);
    checkSeen("tbl_stream", expList);

    // Held done: one burst only, no overrun
    seenData.delete();
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    expList.delete();
    for (int k = 0; k < N_ELEM; k++) expList.push_back(nominal[k]);
    checkSeen("held_stream", expList);
    compare("held_overrun", overrun_o, 1'b0);

    // Overrun: second done edge at idx 3 with ready low is dropped
    seenData.delete();
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < N_ELEM; k++) c_in[k] = 16'h0001;
    applyStimulus(1'b0, 1'b1, 1'b0);
    compare("ovr_flag", overrun_o, 1'b1);
    compare("ovr_idx", out_idx_o, 4'd3);
    compare("ovr_data", out_data_o, 16'd201);
    applyStimulus(1'b0, 1'b0, 1'b1);
    setNominal();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkSeen("ovr_stream", expList);
    compare("ovr_sticky", overrun_o, 1'b1);

    // Reset mid-burst at idx 5 (overrun is still set going in)
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    compare("pre_rst_idx", out_idx_o, 4'd5);
    applyStimulus(1'b1, 1'b0, 1'b1);
    compare("midrst_valid", out_valid_o, 1'b0);
    compare("midrst_idx", out_idx_o, 4'd0);
    compare("midrst_data", out_data_o, 16'd0);
    compare("midrst_busy", busy_o, 1'b0);
    compare("midrst_overrun", overrun_o, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    seenData.delete();
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkSeen("post_rst_stream", expList);

    // Back-to-back: new done edge on the final transfer
    seenData.delete();
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    compare("b2b_pre_last", out_last_o, 1'b1);
    for (int k = 0; k < N_ELEM; k++) c_in[k] = 16'(k + 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    compare("b2b_valid", out_valid_o, 1'b1);
    compare("b2b_data", out_data_o, 16'd1);
    compare("b2b_idx", out_idx_o, 4'd0);
    compare("b2b_overrun", overrun_o, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < N_ELEM; k++) expList.push_back(16'(k + 1));
    checkSeen("b2b_stream", expList);
    setNominal();

    // Randomized traffic against the model
    done_i = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < N_ELEM; k++) c_in[k] = 16'($urandom);
      applyStimulus($urandom_range(0, 299) == 0,
                    ($urandom_range(0, 7) == 0) ? ~done_i : done_i,
                    $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
